// File: rtl/sblk_row_dispatch_if.sv
// Bundle of the instruction, activation, status and completion signals exchanged
// between the row dispatcher (slave) and its environment (master).
interface sblk_row_dispatch_if #(
    parameter int unsigned N_ROW    = 7,
    parameter int unsigned WID_INST = 14,
    parameter int unsigned WID_ACT  = 16
);
    logic [WID_INST-1:0]       inst_in_data;
    logic [N_ROW-1:0]          inst_in_mask;
    logic                      inst_in_vld;
    logic                      inst_in_rdy;
    logic [WID_INST*N_ROW-1:0] inst_data;
    logic [N_ROW-1:0]          inst_en;
    logic [N_ROW-1:0]          status_sblk;
    logic [2*WID_ACT-1:0]      act_in_data;
    logic [N_ROW-1:0]          act_in_mask;
    logic                      act_in_vld;
    logic                      act_in_rdy;
    logic [2*WID_ACT-1:0]      act_data_out;
    logic [N_ROW-1:0]          act_data_out_vld;
    logic [N_ROW-1:0]          act_data_in_req;
    logic [N_ROW-1:0]          row_busy;
    logic                      done_pulse;

    modport slave (
        input  inst_in_data, inst_in_mask, inst_in_vld, status_sblk,
        input  act_in_data, act_in_mask, act_in_vld, act_data_in_req,
        output inst_in_rdy, inst_data, inst_en, act_in_rdy,
        output act_data_out, act_data_out_vld, row_busy, done_pulse
    );

    modport master (
        output inst_in_data, inst_in_mask, inst_in_vld, status_sblk,
        output act_in_data, act_in_mask, act_in_vld, act_data_in_req,
        input  inst_in_rdy, inst_data, inst_en, act_in_rdy,
        input  act_data_out, act_data_out_vld, row_busy, done_pulse
    );
endinterface

// File: rtl/sblk_row_dispatch.sv
// Row dispatcher: masked instruction fan-out into per-row FIFOs with busy-gated issue,
// all-or-nothing activation forwarding, and row/array completion reporting.
module sblk_row_dispatch #(
    parameter int unsigned N_ROW           = 7,
    parameter int unsigned WID_INST        = 14,
    parameter int unsigned WID_ACT         = 16,
    parameter int unsigned INST_FIFO_DEPTH = 4
) (
    input  logic                 clk_h,
    input  logic                 rst,
    sblk_row_dispatch_if.slave   bus
);
    localparam int unsigned WID_FIFO_CNT = $clog2(INST_FIFO_DEPTH + 1);
    localparam int unsigned WID_PTR      = $clog2(INST_FIFO_DEPTH);
    localparam int unsigned WID_BEAT     = 2 * WID_ACT;

    logic [WID_INST-1:0]       mem_q    [N_ROW][INST_FIFO_DEPTH];
    logic [WID_INST-1:0]       mem_d    [N_ROW][INST_FIFO_DEPTH];
    logic [WID_PTR-1:0]        wr_ptr_q [N_ROW];
    logic [WID_PTR-1:0]        wr_ptr_d [N_ROW];
    logic [WID_PTR-1:0]        rd_ptr_q [N_ROW];
    logic [WID_PTR-1:0]        rd_ptr_d [N_ROW];
    logic [WID_FIFO_CNT-1:0]   cnt_q    [N_ROW];
    logic [WID_FIFO_CNT-1:0]   cnt_d    [N_ROW];

    logic [N_ROW-1:0]          pend_q, pend_d;
    logic [N_ROW-1:0]          inst_en_q, inst_en_d;
    logic [N_ROW-1:0]          row_busy_q, row_busy_d;
    logic [WID_INST*N_ROW-1:0] inst_data_q, inst_data_d;
    logic [WID_BEAT-1:0]       act_data_q, act_data_d;
    logic [N_ROW-1:0]          act_vld_q, act_vld_d;
    logic                      all_idle_q, all_idle_d;
    logic                      done_q, done_d;

    logic [N_ROW-1:0]          row_full;
    logic [N_ROW-1:0]          push;
    logic [N_ROW-1:0]          issue;
    logic                      inst_rdy, inst_hs;
    logic                      act_rdy, act_hs;

    // Handshake decode; ready looks only at registered occupancy (no pop bypass).
    always_comb begin
        for (int r = 0; r < N_ROW; r++) begin
            row_full[r] = (cnt_q[r] == WID_FIFO_CNT'(INST_FIFO_DEPTH));
            issue[r]    = (cnt_q[r] != '0) && !pend_q[r] && !bus.status_sblk[r];
        end
        inst_rdy = !rst && ((row_full & bus.inst_in_mask) == '0);
        inst_hs  = inst_rdy && bus.inst_in_vld;
        push     = {N_ROW{inst_hs}} & bus.inst_in_mask;
        act_rdy  = !rst && (&(bus.act_data_in_req | ~bus.act_in_mask));
        act_hs   = act_rdy && bus.act_in_vld;
    end

    // Per-row FIFO, issue and pending tracking.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        inst_en_d   = '0;
        inst_data_d = inst_data_q;
        row_busy_d  = '0;
        for (int r = 0; r < N_ROW; r++) begin
            if (push[r]) begin
                mem_d[r][wr_ptr_q[r]] = bus.inst_in_data;
                wr_ptr_d[r]           = wr_ptr_q[r] + WID_PTR'(1);
            end
            if (issue[r]) begin
                inst_data_d[r*WID_INST +: WID_INST] = mem_q[r][rd_ptr_q[r]];
                rd_ptr_d[r]  = rd_ptr_q[r] + WID_PTR'(1);
                inst_en_d[r] = 1'b1;
                pend_d[r]    = 1'b1;
            end else if (bus.status_sblk[r]) begin
                pend_d[r] = 1'b0;
            end
            cnt_d[r] = cnt_q[r] + WID_FIFO_CNT'(push[r]) - WID_FIFO_CNT'(issue[r]);
            row_busy_d[r] = (cnt_d[r] != '0) || pend_d[r] || bus.status_sblk[r];
        end
    end

    // Activation forwarding and array completion edge detect.
    always_comb begin
        act_data_d = act_data_q;
        act_vld_d  = '0;
        if (act_hs) begin
            act_vld_d = bus.act_in_mask;
            if (bus.act_in_mask != '0) begin
                act_data_d = bus.act_in_data;
            end
        end
        all_idle_d = (bus.status_sblk == '0) && (pend_q == '0);
        for (int r = 0; r < N_ROW; r++) begin
            if (cnt_q[r] != '0) begin
                all_idle_d = 1'b0;
            end
        end
        done_d = all_idle_d && !all_idle_q;
    end

    // all_idle resets high so leaving reset never looks like a 0->1 transition.
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N_ROW; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                cnt_q[r]    <= '0;
                for (int i = 0; i < INST_FIFO_DEPTH; i++) begin
                    mem_q[r][i] <= '0;
                end
            end
            pend_q      <= '0;
            inst_en_q   <= '0;
            row_busy_q  <= '0;
            inst_data_q <= '0;
            act_data_q  <= '0;
            act_vld_q   <= '0;
            all_idle_q  <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            inst_en_q   <= inst_en_d;
            row_busy_q  <= row_busy_d;
            inst_data_q <= inst_data_d;
            act_data_q  <= act_data_d;
            act_vld_q   <= act_vld_d;
            all_idle_q  <= all_idle_d;
            done_q      <= done_d;
        end
    end

    assign bus.inst_in_rdy      = inst_rdy;
    assign bus.act_in_rdy       = act_rdy;
    assign bus.inst_en          = inst_en_q;
    assign bus.inst_data        = inst_data_q;
    assign bus.act_data_out     = act_data_q;
    assign bus.act_data_out_vld = act_vld_q;
    assign bus.row_busy         = row_busy_q;
    assign bus.done_pulse       = done_q;
endmodule

// File: doc/sblk_row_dispatch.md
Name: sblk_row_dispatch

Overview:
Front-end dispatcher for a row of N_ROW superblocks. It takes one shared instruction stream and one shared activation stream, each tagged with a per-row target mask for unicast, multicast or broadcast. Instructions are held in per-row FIFOs and issued to each superblock only when that row is idle. Activations are forwarded all-or-nothing to the targeted rows, and the block reports row-level and array-level completion.

Parameters:
N_ROW, 7, number of superblock rows driven
WID_INST, 14, instruction word width
WID_ACT, 16, activation element width; each beat carries 2 elements
INST_FIFO_DEPTH, 4, per-row instruction FIFO depth; power of 2, at least 2
WID_FIFO_CNT, $clog2(INST_FIFO_DEPTH+1), FIFO occupancy counter width

Ports:
clk_h  in  1  single clock
rst  in  1  asynchronous reset, active-high
inst_in_data  in  WID_INST  shared instruction word
inst_in_mask  in  N_ROW  target rows; bit r set means row r receives the word
inst_in_vld  in  1  instruction valid
inst_in_rdy  out  1  instruction ready
inst_data  out  WID_INST*N_ROW  per-row issued instruction; row r occupies slice [r*WID_INST +: WID_INST]
inst_en  out  N_ROW  per-row one-cycle issue strobe
status_sblk  in  N_ROW  per-row busy flag from the superblocks (1 = busy)
act_in_data  in  2*WID_ACT  shared activation beat
act_in_mask  in  N_ROW  activation target rows
act_in_vld  in  1  activation valid
act_in_rdy  out  1  activation ready
act_data_out  out  2*WID_ACT  registered activation beat, common to all rows
act_data_out_vld  out  N_ROW  per-row activation valid strobe
act_data_in_req  in  N_ROW  per-row activation request from the superblocks
row_busy  out  N_ROW  row r has a FIFO entry, a pending issue, or status_sblk[r] high
done_pulse  out  1  one-cycle pulse when the whole array becomes idle

Behaviour:
- Reset (asynchronous, rst high):
  - All FIFOs flushed; all pending flags cleared.
  - inst_data, inst_en, act_data_out, act_data_out_vld, row_busy, done_pulse all 0.
  - inst_in_rdy and act_in_rdy forced to 0 while rst is high.
- Instruction accept:
  - inst_in_rdy = !rst && (every row r with inst_in_mask[r]=1 has count_r < INST_FIFO_DEPTH).
  - A handshake pushes the word into all masked FIFOs in the same edge (all-or-nothing).
  - inst_in_rdy is computed from the registered count only: no bypass, and a full FIFO is not made ready by a same-cycle pop.
  - inst_in_mask == 0: rdy = !rst, the word is accepted and dropped.
- Per-row issue, for each row r:
  - Issue condition: FIFO non-empty && pending_r == 0 && status_sblk[r] == 0.
  - On issue: inst_en[r] is registered high for exactly one cycle, inst_data slice r is loaded with the FIFO head, the head is popped, and pending_r is set.
  - inst_data slice r holds its value until the next issue to row r.
  - pending_r clears on the first sampled status_sblk[r] == 1.
  - The next issue to row r requires pending_r == 0 and status_sblk[r] == 0; a full busy-then-idle cycle of status_sblk[r] is therefore required between issues.
  - A row that never raises status_sblk stays pending indefinitely. This is the defined behaviour; there is no timeout.
- Latency: handshake in cycle c → earliest inst_en[r] high in cycle c+2, when the FIFO was empty and the row idle.
- Simultaneous push and pop on the same FIFO: count is unchanged; the head advances correctly; FIFO order is preserved.
- Rows issue independently. No ordering exists across rows.
- Activation path:
  - act_in_rdy = !rst && (for all r, act_data_in_req[r] || !act_in_mask[r]).
  - On handshake in cycle c: act_data_out is registered with act_in_data, and act_data_out_vld = act_in_mask for cycle c+1 only, then returns to 0.
  - Back-to-back beats are allowed at one per cycle.
  - act_in_mask == 0: the beat is accepted and dropped; act_data_out_vld stays 0.
- Completion:
  - all_idle (registered) = all FIFOs empty && all pending == 0 && status_sblk == 0.
  - done_pulse goes high for one cycle on a 0→1 transition of all_idle.
  - The first cycle after reset deassertion does not count as a transition, so no pulse is produced from reset.
- Counters: count_r is WID_FIFO_CNT bits. Read and write pointers are $clog2(INST_FIFO_DEPTH) bits and wrap modulo INST_FIFO_DEPTH.

Test Plan:
- Reset: assert rst with 3 entries queued in row 1 → all outputs 0 immediately and both rdy signals 0; after deassert, no inst_en, no done_pulse, and row_busy = 0.
- Unicast: inst_in_mask=0x04, data=0x1A5, handshake in cycle 10 → inst_en=0x04 in cycle 12 only, and inst_data[28+:14]=0x1A5 held afterwards.
- Broadcast backpressure: fill row 3 with 4 entries while status_sblk[3]=1 → with mask=0x7F, inst_in_rdy=0 and no FIFO changes; after row 3 pops one entry → handshake accepted, all 7 FIFOs incremented.
- Status gating: queue A then B to row 0 → A issued; B withheld while status_sblk[0] stays 0 after issue and while it is 1; B issued 1 cycle after status_sblk[0] is sampled 0 following its 1-phase.
- Activation multicast: act_in_mask=0x05, act_data_in_req=0x01 → act_in_rdy=0; set req=0x05 → handshake, then act_data_out_vld=0x05 for exactly 1 cycle with matching data.
- done_pulse: issue one instruction to each of rows 0 and 6, each running a status 1→0 cycle → exactly one done_pulse, in the cycle after both rows are idle.
